// File: rtl/preset_countdown_reader_if.sv
// rtl/preset_countdown_reader_if.sv - preset store read bus (cs/w_r/addr/r_data)
interface preset_countdown_reader_if #(
  parameter int DW = 6
);
  logic          cs;
  logic          w_r;
  logic          addr;
  logic [DW-1:0] r_data;

  modport master (output cs, output w_r, output addr, input r_data);
  modport slave  (input cs, input w_r, input addr, output r_data);
endinterface

// File: rtl/preset_countdown_reader.sv
// rtl/preset_countdown_reader.sv - reads two presets in turn and counts each down per divided tick
// Optional BCD outputs (count_tens/count_ones) under macro BCD_OUT_EN.
module preset_countdown_reader #(
  parameter int DW      = 6,
  parameter int MAX_VAL = 20,
  parameter int CLK_DIV = 50000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              stop,
  preset_countdown_reader_if.master         bus,
  output logic [DW-1:0]                     count,
  output logic                              phase,
  output logic                              busy,
  output logic                              expire,
`ifdef BCD_OUT_EN
  output logic [3:0]                        count_tens,
  output logic [3:0]                        count_ones,
`endif
  output logic                              err
);

  localparam int              DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DW-1:0]    MAX_D    = DW'(MAX_VAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_RUN
  } state_t;

  state_t           state, state_d;
  logic [DW-1:0]    count_d;
  logic [DW-1:0]    rd_q, rd_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_d;
  logic             expire_d;
  logic             err_d;
  logic             zero_q, zero_d;

  // Bus and status outputs decode straight from state so reset clears cs without a clock.
  assign bus.cs   = (state == S_REQ);
  assign bus.w_r  = 1'b1;
  assign bus.addr = phase;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      phase  <= 1'b0;
      expire <= 1'b0;
      err    <= 1'b0;
      div_q  <= '0;
      rd_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      phase  <= phase_d;
      expire <= expire_d;
      err    <= err_d;
      div_q  <= div_d;
      rd_q   <= rd_d;
      zero_q <= zero_d;
    end
  end

  always_comb begin
    state_d  = state;
    count_d  = count;
    phase_d  = phase;
    expire_d = 1'b0;
    err_d    = err;
    div_d    = div_q;
    rd_d     = rd_q;
    zero_d   = zero_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          err_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      // Count is loaded on the edge that samples r_data; LOAD is the first divided cycle.
      S_WAIT: begin
        rd_d  = bus.r_data;
        div_d = '0;
        if (bus.r_data != '0) begin
          count_d = (bus.r_data > MAX_D) ? MAX_D : bus.r_data;
        end
        state_d = S_LOAD;
      end

      S_LOAD: begin
        if (rd_q == '0) begin
          if (zero_q) begin
            err_d   = 1'b1;
            count_d = '0;
            phase_d = 1'b0;
            zero_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            zero_d  = 1'b1;
            phase_d = ~phase;
            state_d = S_REQ;
          end
        end else begin
          zero_d  = 1'b0;
          div_d   = div_q + 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (count == DW'(1)) begin
            count_d  = '0;
            expire_d = 1'b1;
            phase_d  = ~phase;
            state_d  = S_REQ;
          end else if (count > DW'(1)) begin
            count_d = count - 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // stop overrides everything, including a same-cycle expiry
    if (stop) begin
      state_d  = S_IDLE;
      count_d  = count;
      phase_d  = phase;
      expire_d = 1'b0;
      err_d    = err;
      div_d    = '0;
      rd_d     = rd_q;
      zero_d   = zero_q;
    end
  end

`ifdef BCD_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_tens <= 4'd0;
      count_ones <= 4'd0;
    end else begin
      count_tens <= 4'(count_d / DW'(10));
      count_ones <= 4'(count_d % DW'(10));
    end
  end
`endif

endmodule

// File: tb/tb_preset_countdown_reader.sv
// tb/tb_preset_countdown_reader.sv - scoreboard bench with phase-level reference model
module tb_preset_countdown_reader;
  localparam int DW   = 6;
  localparam int MAXV = 20;
  localparam int CD   = 4;

  localparam int K_READ = 0;
  localparam int K_CNT  = 1;
  localparam int K_EXP  = 2;
  localparam int K_ERR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [DW-1:0] count;
  logic phase, busy, expire, err;
`ifdef BCD_OUT_EN
  logic [3:0] ct, co;
`endif

  always #5 clk = ~clk;

  preset_countdown_reader_if #(.DW(DW)) bus ();

  preset_countdown_reader #(.DW(DW), .MAX_VAL(MAXV), .CLK_DIV(CD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .bus(bus),
    .count(count),
    .phase(phase),
    .busy(busy),
    .expire(expire),
`ifdef BCD_OUT_EN
    .count_tens(ct),
    .count_ones(co),
`endif
    .err(err)
  );

  typedef struct {
    int kind;
    int val;
    int gap;
  } evt_t;

  evt_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int reads = 0;
  bit mon_en = 1'b0;
  bit cs_prev = 1'b0;
  int prev_count = 0;
  bit prev_err = 1'b0;
  logic [DW-1:0] mem [2];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Preset store: data presented from the REQ cycle and held through WAIT, noise otherwise.
  always @(negedge clk) begin
    if (bus.cs) bus.r_data = mem[bus.addr];
    else if (!cs_prev) bus.r_data = DW'($urandom);
    cs_prev = bus.cs;
  end

  task automatic take(input int k, input int v);
    evt_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("evt_kind", k, e.kind);
      chk("evt_val", v, e.val);
      if (e.gap >= 0) chk("evt_gap", cyc - last_cyc, e.gap);
      last_cyc = cyc;
`ifdef BCD_OUT_EN
      if (k == K_CNT) begin
        chk("bcd_tens", int'(ct), v / 10);
        chk("bcd_ones", int'(co), v % 10);
      end
`endif
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (int'(count) != prev_count) take(K_CNT, int'(count));
      if (expire) take(K_EXP, 0);
      if (bus.cs) begin
        reads++;
        take(K_READ, int'(bus.addr));
      end
      if (err && !prev_err) take(K_ERR, 0);
    end
    prev_count = int'(count);
    prev_err = err;
  end

  // Phase-level expectation: read, clamp, count down by one per CD cycles, expire, swap.
  task automatic model(input int p0, input int p1, input int nph, output bit want_err);
    int p[2];
    int ph, c, rgap;
    bit zprev;
    p[0] = p0; p[1] = p1;
    ph = 0; zprev = 1'b0; rgap = -1; want_err = 1'b0;
    for (int i = 0; i < nph; i++) begin
      exp_q.push_back('{K_READ, ph, rgap});
      if (p[ph] == 0) begin
        if (zprev) begin
          exp_q.push_back('{K_ERR, 0, 3});
          want_err = 1'b1;
          return;
        end
        zprev = 1'b1;
        rgap = 3;
      end else begin
        zprev = 1'b0;
        c = (p[ph] > MAXV) ? MAXV : p[ph];
        exp_q.push_back('{K_CNT, c, 2});
        for (int k = c - 1; k >= 0; k--) exp_q.push_back('{K_CNT, k, CD});
        exp_q.push_back('{K_EXP, 0, 0});
        rgap = 0;
      end
      ph ^= 1;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_scenario(input int p0, input int p1, input int nph);
    bit want_err;
    int t, held;
    do_reset();
    mem[0] = DW'(p0);
    mem[1] = DW'(p1);
    exp_q.delete();
    model(p0, p1, nph, want_err);
    reads = 0;
    last_cyc = cyc;
    mon_en = 1'b1;
    pulse_start();
    chk("start_lat_cs", int'(bus.cs), 1);
    chk("start_lat_addr", int'(bus.addr), 0);
    t = 0;
    while (exp_q.size() > 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("scenario_drain", exp_q.size(), 0);
    if (want_err) begin
      repeat (10) @(negedge clk);
      chk("err_set", int'(err), 1);
      chk("err_busy", int'(busy), 0);
      chk("err_reads", reads, 2);
      chk("err_count", int'(count), 0);
      chk("err_phase", int'(phase), 0);
      mon_en = 1'b0;
    end else begin
      mon_en = 1'b0;
      @(posedge clk);
      #1 stop = 1'b1;
      held = int'(count);
      @(posedge clk);
      #1 stop = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_cs", int'(bus.cs), 0);
      chk("stop_count_hold", int'(count), held);
      chk("stop_no_expire", int'(expire), 0);
    end
  endtask

  initial begin
    int t, nexp;
    #2;
    chk("rst_cs", int'(bus.cs), 0);
    chk("rst_w_r", int'(bus.w_r), 1);
    chk("rst_addr", int'(bus.addr), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_expire", int'(expire), 0);
    chk("rst_err", int'(err), 0);

    run_scenario(3, 2, 3);
    run_scenario(25, 1, 3);
    run_scenario(0, 5, 3);
    run_scenario(0, 0, 3);
    run_scenario(5, 0, 4);
    for (int i = 0; i < 8; i++) begin
      int a, b;
      a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
      b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
      run_scenario(a, b, 3);
    end

    // stop mid-run with count 2
    do_reset();
    mem[0] = DW'(3);
    mem[1] = DW'(2);
    pulse_start();
    t = 0;
    while (count != DW'(2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_count2", int'(count), 2);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    chk("stop_run_busy", int'(busy), 0);
    chk("stop_run_count", int'(count), 2);
    nexp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (expire || count != DW'(2)) nexp++;
    end
    chk("stop_run_quiet", nexp, 0);

    // simultaneous start and stop from IDLE
    @(posedge clk);
    #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; stop = 1'b0; end
    chk("start_stop_busy", int'(busy), 0);
    chk("start_stop_cs", int'(bus.cs), 0);

    // asynchronous reset while cs is up
    pulse_start();
    chk("req_cs", int'(bus.cs), 1);
    chk("req_count", int'(count), 2);
    rst_n = 1'b0;
    #1;
    chk("async_cs", int'(bus.cs), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_count", int'(count), 0);
    chk("async_w_r", int'(bus.w_r), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
